// File: rtl/mod_mul_barrett.sv
// -----------------------------------------------------------------------------
// mod_mul_barrett
//
// Pipelined modular multiplier, res = (a*b) mod Q, using Barrett reduction.
// It is set up for the Kyber modulus Q = 3329. It sits directly upstream of
// the NTT butterfly subtractor/adder and produces zeta*b for them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         global pipeline advance; 0 holds every stage register
//   in_valid   a, b, tag_in are valid this cycle
//   a, b       12-bit operands (any 12-bit value gives the exact result)
//   tag_in     sideband tag that travels with the operands
//   out_valid  res / tag_out are valid
//   res        (a*b) mod Q, always in [0, Q-1]
//   tag_out    tag_in of the same transaction
//
// Pipeline (one register per stage, 4 enabled cycles of latency)
//   S1  p  = a*b                          (24 bit, exact)
//   S2  qe = (p*M) >> K                   (quotient estimate, 13 bit)
//   S3  r  = p - qe*Q                     (0 <= r < 2Q, low 13 bits)
//   S4  res = (r >= Q) ? r - Q : r
// -----------------------------------------------------------------------------
module mod_mul_barrett #(
    parameter int Q         = 3329,
    parameter int BARRETT_K = 24,
    parameter int BARRETT_M = 5039,
    parameter int TAG_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [11:0]      a,
    input  logic [11:0]      b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    output logic [11:0]      res,
    output logic [TAG_W-1:0] tag_out
);

    localparam logic [12:0] Q13 = 13'(Q);
    localparam logic [36:0] M37 = 37'(BARRETT_M);

    // Stage 1: full product
    logic             v1_q,   v1_d;
    logic [23:0]      p1_q,   p1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    // Stage 2: quotient estimate plus delayed product
    logic             v2_q,   v2_d;
    logic [23:0]      p2_q,   p2_d;
    logic [12:0]      qe2_q,  qe2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;

    // Stage 3: partially reduced remainder
    logic             v3_q,   v3_d;
    logic [12:0]      r3_q,   r3_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;

    // Stage 4: output registers
    logic             v4_q,   v4_d;
    logic [11:0]      res4_q, res4_d;
    logic [TAG_W-1:0] tag4_q, tag4_d;

    logic [36:0] pm_prod;

    always_comb begin
        // NOTE: every comb output gets a default first (hold), so no latch is
        // inferred when en is low.
        v1_d   = v1_q;
        p1_d   = p1_q;
        tag1_d = tag1_q;
        v2_d   = v2_q;
        p2_d   = p2_q;
        qe2_d  = qe2_q;
        tag2_d = tag2_q;
        v3_d   = v3_q;
        r3_d   = r3_q;
        tag3_d = tag3_q;
        v4_d   = v4_q;
        res4_d = res4_q;
        tag4_d = tag4_q;

        // p < 2^24 and M < 2^13, so the 37-bit product never overflows.
        pm_prod = 37'(p1_q) * M37;

        if (en) begin
            // Bubbles move data like real transactions; only the valid bit
            // distinguishes them.
            v1_d   = in_valid;
            p1_d   = 24'(a) * 24'(b);
            tag1_d = tag_in;

            v2_d   = v1_q;
            p2_d   = p1_q;
            qe2_d  = 13'(pm_prod >> BARRETT_K);
            tag2_d = tag1_q;

            // The true difference is below 2Q < 2^13, so modulo-2^13
            // arithmetic on the low bits gives the exact value.
            v3_d   = v2_q;
            r3_d   = p2_q[12:0] - 13'(qe2_q * Q13);
            tag3_d = tag2_q;

            v4_d   = v3_q;
            res4_d = (r3_q >= Q13) ? 12'(r3_q - Q13) : 12'(r3_q);
            tag4_d = tag3_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            p1_q   <= '0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            p2_q   <= '0;
            qe2_q  <= '0;
            tag2_q <= '0;
            v3_q   <= 1'b0;
            r3_q   <= '0;
            tag3_q <= '0;
            v4_q   <= 1'b0;
            res4_q <= '0;
            tag4_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the
            // previous stage's old value on the same edge.
            v1_q   <= v1_d;
            p1_q   <= p1_d;
            tag1_q <= tag1_d;
            v2_q   <= v2_d;
            p2_q   <= p2_d;
            qe2_q  <= qe2_d;
            tag2_q <= tag2_d;
            v3_q   <= v3_d;
            r3_q   <= r3_d;
            tag3_q <= tag3_d;
            v4_q   <= v4_d;
            res4_q <= res4_d;
            tag4_q <= tag4_d;
        end
    end

    assign out_valid = v4_q;
    assign res       = res4_q;
    assign tag_out   = tag4_q;

endmodule
